note_recorder: RTL and testbench
================================

# note_recorder

Records live key presses into the song store so recorded tunes can be replayed exactly like the built-in Little Star ROM. Sits upstream of the song memory: drives the write port of a dual-port block RAM whose read port feeds the note player and Buzzer. It converts debounced key presses and rests into timed entries, then writes the entry count to address 0 on stop.

## Interface
- TICK_CYCLES, 10_000_000: clk cycles per duration unit (100 ms at 100 MHz)
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized key vector must be stable before it is accepted
- ADDR_W, 7: song RAM address width; address 0 is the header
- DUR_W, 6: duration field width, in TICK units
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- rec_en  in  1  level; high = recording, falling edge = stop and finalize
- keys  in  7  raw note keys, asynchronous, active-high
- pitch  in  3  octave/pitch selector, sampled at note start
- we  out  1  RAM write strobe, one cycle per entry
- waddr  out  ADDR_W  RAM write address
- wdata  out  16  entry: [15:9] note one-hot, [8:6] pitch, [5:0] duration; [15:6] is the player's 10-bit note+pitch bus
- count  out  ADDR_W  entries written in the current or last take
- recording  out  1  high in ARMED/TRACK
- full  out  1  set when count reaches 2^ADDR_W-1

## Operation
- Input path: 2-FF synchronizer on keys, then debounce, then priority select.
  - Priority select keeps the lowest set bit, so the output is one-hot or zero.
  - The result is `cur_note`.
- FSM states: IDLE, ARMED, TRACK, CLOSE, HEADER.
- IDLE → ARMED on rising rec_en. Clears count, full, duration and tick counters.
- ARMED: waits for the first non-zero `cur_note`. Leading silence is never recorded.
  - On the first non-zero `cur_note`: latch note and pitch, zero the duration, go to TRACK.
- TRACK: the duration counter advances one unit per TICK_CYCLES and saturates at 2^DUR_W-1.
- Segment closes whenever `cur_note` changes (press, release, or switch to another key):
  - Write {seg_note, seg_pitch, max(dur,1)}. A rest is written with note=0, pitch=0.
  - Open the new segment in the same cycle, with the tick counter reset.
- Entry n (1-based) goes to waddr=n; count becomes n in the write cycle.
- rec_en low while in ARMED or TRACK → CLOSE.
  - CLOSE: writes the open segment only if it is a note. A trailing rest is discarded.
  - Then HEADER.
- Reaching full → HEADER after the write that filled the store. Further key activity is ignored.
- HEADER: writes waddr=0, wdata={zeros, count}, then returns to IDLE.
  - A new take needs rec_en to go low, then high again.
- At most one write per cycle.
  - If rec_en falls in the same cycle as a key change, CLOSE writes the segment active before the change.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; we=0, waddr=0, wdata=0, count=0, recording=0, full=0.
  - Reset mid-take: RAM is left as is; no header is written.
- Key to `cur_note` latency: 2 + DEBOUNCE_CYCLES cycles of stable input.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- The segment write occurs on the cycle after `cur_note` changes. we is high for exactly 1 cycle.
- rec_en fall to CLOSE: 1 cycle. CLOSE to HEADER: 1 cycle. The HEADER write comes 2 cycles after rec_en is sampled low.
- Duration = whole TICK periods elapsed since the segment opened, minimum 1, saturating at 63.
- `count` is stable outside write cycles. `full` stays set until the next take starts.

## Structure
- para.v holds the shared constants:
  - entry field positions: NOTE_MSB/LSB, PITCH_MSB/LSB, DUR_MSB/LSB
  - HEADER_ADDR = 0
  - ENTRY_W = 16
- The player reads note+pitch from the same positions.
- Sub-module `key_debounce`: synchronizer plus a stability counter, parameterised by width and DEBOUNCE_CYCLES.
- The FSM, tick counter, duration counter and write port stay in note_recorder.

## Test plan
Bench uses TICK_CYCLES=10 and DEBOUNCE_CYCLES=4.
- Basic take: rec_en=1; press keys=7'b0000001 with pitch=3 for 35 cycles; release for 22 cycles; press 7'b0000100 for 12 cycles; drop rec_en.
  - Writes: addr1={0000001,011,3}, addr2={0,0,2}, addr3={0000100,…,1}, addr0=3.
- Glitch rejection: a 3-cycle key pulse produces no write. A 2-cycle drop mid-note does not split the note.
- Leading and trailing rests: a 50-cycle silence before the first press and after the last release is not recorded. count equals the number of notes only.
- Saturation and minimum: a 700-cycle hold writes dur=63. A press released after 6 stable cycles writes dur=1.
- Full: ADDR_W=3; alternate 7 segments.
  - full=1 after waddr=7, then the header {…,7} at addr0.
  - Later key presses cause no we.
- Async reset: assert rst_n=0 mid-TRACK.
  - All outputs are 0 immediately; no header is written.
  - After release, a new rec_en rise starts at waddr=1.

Source files
------------

// File: rtl/note_recorder_pkg.sv
// Shared constants and helpers for the song-entry format used by the note
// recorder (writer) and the note player (reader).
package note_recorder_pkg;

    localparam int unsigned ENTRY_W     = 16;
    localparam int unsigned NOTE_W      = 7;
    localparam int unsigned PITCH_W     = 3;
    localparam int unsigned DUR_FIELD_W = 6;

    localparam int unsigned NOTE_MSB    = 15;
    localparam int unsigned NOTE_LSB    = 9;
    localparam int unsigned PITCH_MSB   = 8;
    localparam int unsigned PITCH_LSB   = 6;
    localparam int unsigned DUR_MSB     = 5;
    localparam int unsigned DUR_LSB     = 0;

    localparam int unsigned HEADER_ADDR = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TRACK,
        ST_CLOSE,
        ST_HEADER
    } rec_state_t;

    // Keep only the lowest set bit, so simultaneous keys collapse to one-hot.
    function automatic logic [NOTE_W-1:0] lowest_set(input logic [NOTE_W-1:0] v);
        return v & (~v + {{(NOTE_W-1){1'b0}}, 1'b1});
    endfunction

    // Assemble one song entry from its fields.
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [NOTE_W-1:0]      note,
        input logic [PITCH_W-1:0]     pitch,
        input logic [DUR_FIELD_W-1:0] dur
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[NOTE_MSB:NOTE_LSB]   = note;
        e[PITCH_MSB:PITCH_LSB] = pitch;
        e[DUR_MSB:DUR_LSB]     = dur;
        return e;
    endfunction

endpackage

// File: rtl/note_recorder_key_debounce.sv
// Two-flop synchronizer followed by a stability counter: the output only
// follows the synchronized vector once it has held still for DEBOUNCE_CYCLES.
module key_debounce #(
    parameter int unsigned WIDTH           = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Synchronize, then restart the stability count on any change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_last   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
            if (r_sync2 != r_last) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_last;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/note_recorder.sv
// Converts debounced key presses and rests into timed song entries and
// drives the write port of the song RAM; the entry count goes to address 0
// when a take ends.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned ADDR_W          = 7,
    parameter int unsigned DUR_W           = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rec_en,
    input  logic [NOTE_W-1:0]   keys,
    input  logic [PITCH_W-1:0]  pitch,
    output logic                we,
    output logic [ADDR_W-1:0]   waddr,
    output logic [ENTRY_W-1:0]  wdata,
    output logic [ADDR_W-1:0]   count,
    output logic                recording,
    output logic                full
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    // The opening cycle of a segment already counts as one elapsed cycle.
    localparam logic [TICK_W-1:0] TICK_OPEN  = (TICK_CYCLES > 1) ? TICK_W'(1) : TICK_W'(0);
    localparam logic [DUR_W-1:0]  DUR_OPEN   = (TICK_CYCLES > 1) ? DUR_W'(0) : DUR_W'(1);
    localparam logic [DUR_W-1:0]  DUR_MAX    = '1;
    localparam logic [ADDR_W-1:0] COUNT_FULL = '1;

    rec_state_t          r_state;
    rec_state_t          w_state_nxt;
    logic                r_rec_d;
    logic [TICK_W-1:0]   r_tick,      w_tick_nxt;
    logic [DUR_W-1:0]    r_dur,       w_dur_nxt;
    logic [NOTE_W-1:0]   r_seg_note,  w_seg_note_nxt;
    logic [PITCH_W-1:0]  r_seg_pitch, w_seg_pitch_nxt;
    logic [ADDR_W-1:0]   r_count,     w_count_nxt;
    logic                r_full,      w_full_nxt;
    logic                r_we,        w_we_nxt;
    logic [ADDR_W-1:0]   r_waddr,     w_waddr_nxt;
    logic [ENTRY_W-1:0]  r_wdata,     w_wdata_nxt;

    logic [NOTE_W-1:0]   w_keys_db;
    logic [NOTE_W-1:0]   w_cur_note;
    logic [DUR_W-1:0]    w_dur_min;
    logic [ADDR_W-1:0]   w_count_inc;
    logic [ENTRY_W-1:0]  w_seg_entry;

    key_debounce #(
        .WIDTH           (NOTE_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    (keys),
        .o_stable (w_keys_db)
    );

    assign w_cur_note  = lowest_set(w_keys_db);
    assign w_dur_min   = (r_dur == '0) ? DUR_W'(1) : r_dur;
    assign w_count_inc = r_count + 1'b1;
    assign w_seg_entry = pack_entry(r_seg_note, r_seg_pitch, DUR_FIELD_W'(w_dur_min));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Segment, counter and write-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_d     <= 1'b0;
            r_tick      <= '0;
            r_dur       <= '0;
            r_seg_note  <= '0;
            r_seg_pitch <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_rec_d     <= rec_en;
            r_tick      <= w_tick_nxt;
            r_dur       <= w_dur_nxt;
            r_seg_note  <= w_seg_note_nxt;
            r_seg_pitch <= w_seg_pitch_nxt;
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_we        <= w_we_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    // Next-state, segment tracking and write generation.
    always_comb begin
        w_state_nxt     = r_state;
        w_tick_nxt      = r_tick;
        w_dur_nxt       = r_dur;
        w_seg_note_nxt  = r_seg_note;
        w_seg_pitch_nxt = r_seg_pitch;
        w_count_nxt     = r_count;
        w_full_nxt      = r_full;
        w_we_nxt        = 1'b0;
        w_waddr_nxt     = r_waddr;
        w_wdata_nxt     = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (rec_en && !r_rec_d) begin
                    w_state_nxt     = ST_ARMED;
                    w_count_nxt     = '0;
                    w_full_nxt      = 1'b0;
                    w_dur_nxt       = '0;
                    w_tick_nxt      = '0;
                    w_seg_note_nxt  = '0;
                    w_seg_pitch_nxt = '0;
                end
            end

            ST_ARMED: begin
                if (!rec_en) begin
                    w_state_nxt = ST_CLOSE;
                end else if (w_cur_note != '0) begin
                    w_state_nxt     = ST_TRACK;
                    w_seg_note_nxt  = w_cur_note;
                    w_seg_pitch_nxt = pitch;
                    w_tick_nxt      = TICK_OPEN;
                    w_dur_nxt       = DUR_OPEN;
                end
            end

            ST_TRACK: begin
                // A stop takes precedence over a simultaneous key change so
                // CLOSE sees the segment that was open before the change.
                if (!rec_en) begin
                    w_state_nxt = ST_CLOSE;
                end else if (w_cur_note != r_seg_note) begin
                    w_we_nxt        = 1'b1;
                    w_waddr_nxt     = w_count_inc;
                    w_wdata_nxt     = w_seg_entry;
                    w_count_nxt     = w_count_inc;
                    w_seg_note_nxt  = w_cur_note;
                    w_seg_pitch_nxt = (w_cur_note != '0) ? pitch : '0;
                    w_tick_nxt      = TICK_OPEN;
                    w_dur_nxt       = DUR_OPEN;
                    if (w_count_inc == COUNT_FULL) begin
                        w_full_nxt  = 1'b1;
                        w_state_nxt = ST_HEADER;
                    end
                end else if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (r_dur != DUR_MAX) begin
                        w_dur_nxt = r_dur + 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end

            ST_CLOSE: begin
                w_state_nxt = ST_HEADER;
                if (r_seg_note != '0) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = w_count_inc;
                    w_wdata_nxt = w_seg_entry;
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == COUNT_FULL) begin
                        w_full_nxt = 1'b1;
                    end
                end
            end

            ST_HEADER: begin
                w_state_nxt = ST_IDLE;
                w_we_nxt    = 1'b1;
                w_waddr_nxt = ADDR_W'(HEADER_ADDR);
                w_wdata_nxt = ENTRY_W'(r_count);
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign count     = r_count;
    assign full      = r_full;
    assign recording = (r_state == ST_ARMED) || (r_state == ST_TRACK);

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: one instance with the default 7-bit
// address for the take scenarios, one with a 3-bit address for the full case.
module tb_note_recorder;

    localparam int unsigned TICK = 10;
    localparam int unsigned DEB  = 4;
    localparam int unsigned AW_A = 7;
    localparam int unsigned AW_B = 3;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            rec_a  = 1'b0;
    logic            rec_b  = 1'b0;
    logic [6:0]      keys_a = '0;
    logic [6:0]      keys_b = '0;
    logic [2:0]      pitch_a = '0;
    logic [2:0]      pitch_b = '0;

    logic            we_a, we_b;
    logic [AW_A-1:0] waddr_a, count_a;
    logic [AW_B-1:0] waddr_b, count_b;
    logic [15:0]     wdata_a, wdata_b;
    logic            recording_a, recording_b, full_a, full_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int unsigned addr;
        logic [15:0] data;
        logic        full;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];

    note_recorder #(
        .TICK_CYCLES     (TICK),
        .DEBOUNCE_CYCLES (DEB),
        .ADDR_W          (AW_A),
        .DUR_W           (6)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rec_en    (rec_a),
        .keys      (keys_a),
        .pitch     (pitch_a),
        .we        (we_a),
        .waddr     (waddr_a),
        .wdata     (wdata_a),
        .count     (count_a),
        .recording (recording_a),
        .full      (full_a)
    );

    note_recorder #(
        .TICK_CYCLES     (TICK),
        .DEBOUNCE_CYCLES (DEB),
        .ADDR_W          (AW_B),
        .DUR_W           (6)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rec_en    (rec_b),
        .keys      (keys_b),
        .pitch     (pitch_b),
        .we        (we_b),
        .waddr     (waddr_b),
        .wdata     (wdata_b),
        .count     (count_b),
        .recording (recording_b),
        .full      (full_b)
    );

    always #5 clk = ~clk;

    // Log every write seen on each RAM port, sampled between rising edges.
    always @(negedge clk) begin : mon_a
        wr_t w;
        if (we_a === 1'b1) begin
            w.addr = waddr_a;
            w.data = wdata_a;
            w.full = full_a;
            q_a.push_back(w);
        end
    end

    always @(negedge clk) begin : mon_b
        wr_t w;
        if (we_b === 1'b1) begin
            w.addr = waddr_b;
            w.data = wdata_b;
            w.full = full_b;
            q_b.push_back(w);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        hold(3);
        n_vec++;
        if ({we_a, waddr_a, wdata_a, count_a, recording_a, full_a} !== '0) begin
            n_err++;
            $display("FAIL reset_a: got we=%b waddr=%0d wdata=%h count=%0d rec=%b full=%b, want all 0",
                     we_a, waddr_a, wdata_a, count_a, recording_a, full_a);
        end
        n_vec++;
        if ({we_b, waddr_b, wdata_b, count_b, recording_b, full_b} !== '0) begin
            n_err++;
            $display("FAIL reset_b: got we=%b waddr=%0d wdata=%h count=%0d rec=%b full=%b, want all 0",
                     we_b, waddr_b, wdata_b, count_b, recording_b, full_b);
        end
        rst_n = 1'b1;
        hold(2);
    endtask

    task automatic test_basic;
        int unsigned ea [4] = '{1, 2, 3, 0};
        logic [15:0] ed [4] = '{{7'b0000001, 3'd3, 6'd3}, 16'h0002,
                                {7'b0000100, 3'd3, 6'd1}, 16'h0003};
        q_a.delete();
        rec_a = 1'b1;
        hold(3);
        n_vec++;
        if (recording_a !== 1'b1) begin
            n_err++;
            $display("FAIL basic_armed: recording=%b, want 1", recording_a);
        end
        keys_a = 7'b0000001; pitch_a = 3'd3; hold(35);
        keys_a = '0;                         hold(22);
        keys_a = 7'b0000100;                 hold(12);
        rec_a = 1'b0; keys_a = '0;           hold(20);
        n_vec++;
        if (q_a.size() !== 4) begin
            n_err++;
            $display("FAIL basic_nwrites: got %0d writes, want 4", q_a.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= q_a.size()) begin
                n_err++;
                $display("FAIL basic_w%0d: missing, want addr=%0d data=%h", i, ea[i], ed[i]);
            end else if (q_a[i].addr !== ea[i] || q_a[i].data !== ed[i]) begin
                n_err++;
                $display("FAIL basic_w%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, q_a[i].addr, q_a[i].data, ea[i], ed[i]);
            end
        end
        n_vec++;
        if ({count_a, recording_a, full_a} !== {7'd3, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_end: got count=%0d rec=%b full=%b, want count=3 rec=0 full=0",
                     count_a, recording_a, full_a);
        end
    endtask

    task automatic test_glitch;
        int unsigned ea [2] = '{1, 0};
        logic [15:0] ed [2] = '{{7'b0000010, 3'd5, 6'd3}, 16'h0001};
        q_a.delete();
        rec_a = 1'b1; hold(5);
        keys_a = 7'b0000010; hold(3);
        keys_a = '0;         hold(20);
        n_vec++;
        if (q_a.size() !== 0 || recording_a !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_pulse: got %0d writes rec=%b, want 0 writes rec=1",
                     q_a.size(), recording_a);
        end
        pitch_a = 3'd5;
        keys_a = 7'b0000010; hold(15);
        keys_a = '0;         hold(2);
        keys_a = 7'b0000010; hold(13);
        keys_a = '0;         hold(15);
        rec_a = 1'b0;        hold(20);
        n_vec++;
        if (q_a.size() !== 2) begin
            n_err++;
            $display("FAIL glitch_nwrites: got %0d writes, want 2", q_a.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= q_a.size()) begin
                n_err++;
                $display("FAIL glitch_w%0d: missing, want addr=%0d data=%h", i, ea[i], ed[i]);
            end else if (q_a[i].addr !== ea[i] || q_a[i].data !== ed[i]) begin
                n_err++;
                $display("FAIL glitch_w%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, q_a[i].addr, q_a[i].data, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_lead_trail;
        int unsigned ea [2] = '{1, 0};
        logic [15:0] ed [2] = '{{7'b0001000, 3'd1, 6'd2}, 16'h0001};
        q_a.delete();
        rec_a = 1'b1; hold(50);
        keys_a = 7'b0001000; pitch_a = 3'd1; hold(20);
        keys_a = '0;                         hold(50);
        rec_a = 1'b0;                        hold(20);
        n_vec++;
        if (q_a.size() !== 2) begin
            n_err++;
            $display("FAIL leadtrail_nwrites: got %0d writes, want 2", q_a.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= q_a.size()) begin
                n_err++;
                $display("FAIL leadtrail_w%0d: missing, want addr=%0d data=%h", i, ea[i], ed[i]);
            end else if (q_a[i].addr !== ea[i] || q_a[i].data !== ed[i]) begin
                n_err++;
                $display("FAIL leadtrail_w%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, q_a[i].addr, q_a[i].data, ea[i], ed[i]);
            end
        end
        n_vec++;
        if (count_a !== 7'd1) begin
            n_err++;
            $display("FAIL leadtrail_count: got %0d, want 1", count_a);
        end
    endtask

    task automatic test_sat_min;
        int unsigned ea [4] = '{1, 2, 3, 0};
        logic [15:0] ed [4] = '{{7'b0100000, 3'd7, 6'd63}, 16'h0002,
                                {7'b0000001, 3'd0, 6'd1}, 16'h0003};
        q_a.delete();
        rec_a = 1'b1; hold(5);
        keys_a = 7'b1100000; pitch_a = 3'd7; hold(700);
        keys_a = '0;                         hold(20);
        keys_a = 7'b0000001; pitch_a = 3'd0; hold(6);
        keys_a = '0;                         hold(20);
        rec_a = 1'b0;                        hold(20);
        n_vec++;
        if (q_a.size() !== 4) begin
            n_err++;
            $display("FAIL satmin_nwrites: got %0d writes, want 4", q_a.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= q_a.size()) begin
                n_err++;
                $display("FAIL satmin_w%0d: missing, want addr=%0d data=%h", i, ea[i], ed[i]);
            end else if (q_a[i].addr !== ea[i] || q_a[i].data !== ed[i]) begin
                n_err++;
                $display("FAIL satmin_w%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, q_a[i].addr, q_a[i].data, ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_full;
        int unsigned ea [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        logic [15:0] ed [8];
        logic        ef [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            ed[i] = (i % 2 == 0) ? {7'b0000001, 3'd2, 6'd1} : 16'h0001;
        end
        ed[7] = 16'h0007;
        q_b.delete();
        rec_b = 1'b1; pitch_b = 3'd2; hold(5);
        for (int s = 0; s < 4; s++) begin
            keys_b = 7'b0000001; hold(12);
            keys_b = '0;         hold(12);
        end
        hold(5);
        n_vec++;
        if (q_b.size() !== 8) begin
            n_err++;
            $display("FAIL full_nwrites: got %0d writes, want 8", q_b.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (i >= q_b.size()) begin
                n_err++;
                $display("FAIL full_w%0d: missing, want addr=%0d data=%h full=%b", i, ea[i], ed[i], ef[i]);
            end else if (q_b[i].addr !== ea[i] || q_b[i].data !== ed[i] || q_b[i].full !== ef[i]) begin
                n_err++;
                $display("FAIL full_w%0d: got addr=%0d data=%h full=%b, want addr=%0d data=%h full=%b",
                         i, q_b[i].addr, q_b[i].data, q_b[i].full, ea[i], ed[i], ef[i]);
            end
        end
        q_b.delete();
        for (int s = 0; s < 2; s++) begin
            keys_b = 7'b0000100; hold(12);
            keys_b = '0;         hold(12);
        end
        n_vec++;
        if (q_b.size() !== 0) begin
            n_err++;
            $display("FAIL full_ignore: got %0d writes after full, want 0", q_b.size());
        end
        n_vec++;
        if ({full_b, count_b, recording_b} !== {1'b1, 3'd7, 1'b0}) begin
            n_err++;
            $display("FAIL full_flags: got full=%b count=%0d rec=%b, want full=1 count=7 rec=0",
                     full_b, count_b, recording_b);
        end
        rec_b = 1'b0;
        hold(3);
    endtask

    task automatic test_async_reset;
        int unsigned ea [2] = '{1, 0};
        logic [15:0] ed [2] = '{{7'b0001000, 3'd4, 6'd1}, 16'h0001};
        q_a.delete();
        rec_a = 1'b1; hold(3);
        keys_a = 7'b0001000; pitch_a = 3'd4; hold(25);
        n_vec++;
        if (recording_a !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: recording=%b, want 1", recording_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({we_a, waddr_a, wdata_a, count_a, recording_a, full_a} !== '0) begin
            n_err++;
            $display("FAIL areset_now: got we=%b waddr=%0d wdata=%h count=%0d rec=%b full=%b, want all 0",
                     we_a, waddr_a, wdata_a, count_a, recording_a, full_a);
        end
        hold(3);
        rec_a = 1'b0; keys_a = '0;
        hold(1);
        rst_n = 1'b1;
        hold(20);
        n_vec++;
        if (q_a.size() !== 0) begin
            n_err++;
            $display("FAIL areset_noheader: got %0d writes, want 0", q_a.size());
        end
        rec_a = 1'b1;        hold(3);
        keys_a = 7'b0001000; hold(15);
        keys_a = '0;         hold(15);
        rec_a = 1'b0;        hold(20);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= q_a.size()) begin
                n_err++;
                $display("FAIL areset_w%0d: missing, want addr=%0d data=%h", i, ea[i], ed[i]);
            end else if (q_a[i].addr !== ea[i] || q_a[i].data !== ed[i]) begin
                n_err++;
                $display("FAIL areset_w%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         i, q_a[i].addr, q_a[i].data, ea[i], ed[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_lead_trail();
        test_sat_min();
        test_full();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
